// File: rtl/chip8_pkg.sv
// CHIP-8 shared definitions: decoded opcode indices, stack placement and the
// random-number LFSR step used by RND.
package chip8_pkg;

    localparam logic [6:0] OP_NOP    = 7'd0;
    localparam logic [6:0] OP_JP     = 7'd1;
    localparam logic [6:0] OP_CALL   = 7'd2;
    localparam logic [6:0] OP_RET    = 7'd3;
    localparam logic [6:0] OP_SE_KK  = 7'd4;
    localparam logic [6:0] OP_SNE_KK = 7'd5;
    localparam logic [6:0] OP_SE_VY  = 7'd6;
    localparam logic [6:0] OP_SNE_VY = 7'd7;
    localparam logic [6:0] OP_LD_KK  = 7'd8;
    localparam logic [6:0] OP_ADD_KK = 7'd9;
    localparam logic [6:0] OP_LD_VY  = 7'd10;
    localparam logic [6:0] OP_OR     = 7'd11;
    localparam logic [6:0] OP_AND    = 7'd12;
    localparam logic [6:0] OP_XOR    = 7'd13;
    localparam logic [6:0] OP_ADD    = 7'd14;
    localparam logic [6:0] OP_SUB    = 7'd15;
    localparam logic [6:0] OP_SHR    = 7'd16;
    localparam logic [6:0] OP_SUBN   = 7'd17;
    localparam logic [6:0] OP_SHL    = 7'd18;
    localparam logic [6:0] OP_LDI    = 7'd19;
    localparam logic [6:0] OP_JPV0   = 7'd20;
    localparam logic [6:0] OP_RND    = 7'd21;
    localparam logic [6:0] OP_ADDI   = 7'd22;

    localparam logic [15:0] STACK_BASE_DEFAULT = 16'h0EA0;
    localparam logic [7:0]  LFSR_SEED          = 8'hA5;

    // Galois right-shift form of x^8+x^6+x^5+x^4+1 (toggle mask 0xB8)
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

endpackage

// File: rtl/chip8_alu.sv
// Combinational register-register ALU for the 8xy_ group; flag is the value
// destined for VF (only meaningful for ADD/SUB/SHR/SUBN/SHL).
module chip8_alu
    import chip8_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [7:0] vx_i,
    input  logic [7:0] vy_i,
    output logic [7:0] res_o,
    output logic       flag_o
);

    logic [8:0] sum;
    logic [8:0] diff_xy;
    logic [8:0] diff_yx;

    assign sum     = {1'b0, vx_i} + {1'b0, vy_i};
    assign diff_xy = {1'b0, vx_i} - {1'b0, vy_i};
    assign diff_yx = {1'b0, vy_i} - {1'b0, vx_i};

    // Borrow out of the 9-bit difference is the inverse of "no borrow" flag
    always_comb begin
        res_o  = '0;
        flag_o = 1'b0;
        unique case (op_i)
            OP_LD_VY: res_o = vy_i;
            OP_OR:    res_o = vx_i | vy_i;
            OP_AND:   res_o = vx_i & vy_i;
            OP_XOR:   res_o = vx_i ^ vy_i;
            OP_ADD: begin
                res_o  = sum[7:0];
                flag_o = sum[8];
            end
            OP_SUB: begin
                res_o  = diff_xy[7:0];
                flag_o = ~diff_xy[8];
            end
            OP_SHR: begin
                res_o  = {1'b0, vx_i[7:1]};
                flag_o = vx_i[0];
            end
            OP_SUBN: begin
                res_o  = diff_yx[7:0];
                flag_o = ~diff_yx[8];
            end
            OP_SHL: begin
                res_o  = {vx_i[6:0], 1'b0};
                flag_o = vx_i[7];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/execute.sv
// CHIP-8 execute stage: one decoded instruction per cycle in, registered
// write-back / memory requests out one cycle later, each with a 1-cycle enable.
module execute
    import chip8_pkg::*;
#(
    parameter logic [15:0] STACK_BASE = STACK_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  i_decode,
    input  logic [7:0]  i_byte_kk,
    input  logic [7:0]  i_vx_data,
    input  logic [7:0]  i_vy_data,
    input  logic [3:0]  i_vx_addr,
    output logic [3:0]  o_vx_addr,
    output logic [7:0]  o_vx_data,
    output logic [7:0]  o_vf_data,
    output logic        o_vf_en,
    output logic        o_vx_en,
    input  logic [11:0] i_mem_addr,
    input  logic [15:0] i_pc_data,
    input  logic [7:0]  i_sp_data,
    input  logic [15:0] i_i_data,
    output logic        o_mem_w_en,
    output logic [15:0] o_mem_w_addr,
    output logic [15:0] o_mem_w_data,
    output logic        o_mem_r_en,
    output logic [15:0] o_mem_r_addr,
    output logic [15:0] o_mem_r_data,
    output logic [15:0] o_pc_data,
    output logic        o_pc_en,
    output logic [7:0]  o_sp_data,
    output logic        o_sp_en,
    output logic [15:0] o_i_data,
    output logic        o_i_en
);

    logic [3:0]  vx_addr_q, vx_addr_d;
    logic [7:0]  vx_data_q, vx_data_d;
    logic [7:0]  vf_data_q, vf_data_d;
    logic        vx_en_q, vx_en_d;
    logic        vf_en_q, vf_en_d;
    logic        mem_w_en_q, mem_w_en_d;
    logic [15:0] mem_w_addr_q, mem_w_addr_d;
    logic [15:0] mem_w_data_q, mem_w_data_d;
    logic        mem_r_en_q, mem_r_en_d;
    logic [15:0] mem_r_addr_q, mem_r_addr_d;
    logic [15:0] pc_data_q, pc_data_d;
    logic        pc_en_q, pc_en_d;
    logic [7:0]  sp_data_q, sp_data_d;
    logic        sp_en_q, sp_en_d;
    logic [15:0] i_data_q, i_data_d;
    logic        i_en_q, i_en_d;
    logic [7:0]  lfsr_q, lfsr_d;

    logic [7:0]  alu_res;
    logic        alu_flag;
    logic [7:0]  sp_inc, sp_dec;
    logic [15:0] nnn16, pc_skip, push_addr, pop_addr;

    chip8_alu u_alu (
        .op_i   (i_decode),
        .vx_i   (i_vx_data),
        .vy_i   (i_vy_data),
        .res_o  (alu_res),
        .flag_o (alu_flag)
    );

    assign sp_inc    = i_sp_data + 8'd1;
    assign sp_dec    = i_sp_data - 8'd1;
    assign nnn16     = {4'h0, i_mem_addr};
    assign pc_skip   = i_pc_data + 16'd2;
    assign push_addr = STACK_BASE + {7'b0, i_sp_data, 1'b0};
    assign pop_addr  = STACK_BASE + {7'b0, sp_dec, 1'b0};

    always_comb begin
        vx_addr_d    = i_vx_addr;
        vx_data_d    = vx_data_q;
        vf_data_d    = vf_data_q;
        vx_en_d      = 1'b0;
        vf_en_d      = 1'b0;
        mem_w_en_d   = 1'b0;
        mem_w_addr_d = mem_w_addr_q;
        mem_w_data_d = mem_w_data_q;
        mem_r_en_d   = 1'b0;
        mem_r_addr_d = mem_r_addr_q;
        pc_data_d    = pc_data_q;
        pc_en_d      = 1'b0;
        sp_data_d    = sp_data_q;
        sp_en_d      = 1'b0;
        i_data_d     = i_data_q;
        i_en_d       = 1'b0;
        lfsr_d       = lfsr_next(lfsr_q);

        unique case (i_decode)
            OP_JP: begin
                pc_data_d = nnn16;
                pc_en_d   = 1'b1;
            end
            OP_CALL: begin
                mem_w_addr_d = push_addr;
                mem_w_data_d = i_pc_data;
                mem_w_en_d   = 1'b1;
                sp_data_d    = sp_inc;
                sp_en_d      = 1'b1;
                pc_data_d    = nnn16;
                pc_en_d      = 1'b1;
            end
            // Return address arrives via the read; fetch owns the PC load here
            OP_RET: begin
                mem_r_addr_d = pop_addr;
                mem_r_en_d   = 1'b1;
                sp_data_d    = sp_dec;
                sp_en_d      = 1'b1;
            end
            OP_SE_KK, OP_SNE_KK, OP_SE_VY, OP_SNE_VY: begin
                if (((i_decode == OP_SE_KK)  && (i_vx_data == i_byte_kk)) ||
                    ((i_decode == OP_SNE_KK) && (i_vx_data != i_byte_kk)) ||
                    ((i_decode == OP_SE_VY)  && (i_vx_data == i_vy_data)) ||
                    ((i_decode == OP_SNE_VY) && (i_vx_data != i_vy_data))) begin
                    pc_data_d = pc_skip;
                    pc_en_d   = 1'b1;
                end
            end
            OP_LD_KK: begin
                vx_data_d = i_byte_kk;
                vx_en_d   = 1'b1;
            end
            OP_ADD_KK: begin
                vx_data_d = i_vx_data + i_byte_kk;
                vx_en_d   = 1'b1;
            end
            OP_LD_VY, OP_OR, OP_AND, OP_XOR: begin
                vx_data_d = alu_res;
                vx_en_d   = 1'b1;
            end
            OP_ADD, OP_SUB, OP_SHR, OP_SUBN, OP_SHL: begin
                vx_data_d = alu_res;
                vx_en_d   = 1'b1;
                vf_data_d = {7'b0, alu_flag};
                vf_en_d   = 1'b1;
            end
            OP_LDI: begin
                i_data_d = nnn16;
                i_en_d   = 1'b1;
            end
            OP_JPV0: begin
                pc_data_d = nnn16 + {8'h00, i_vx_data};
                pc_en_d   = 1'b1;
            end
            OP_RND: begin
                vx_data_d = lfsr_q & i_byte_kk;
                vx_en_d   = 1'b1;
            end
            OP_ADDI: begin
                i_data_d = i_i_data + {8'h00, i_vx_data};
                i_en_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vx_addr_q    <= '0;
            vx_data_q    <= '0;
            vf_data_q    <= '0;
            vx_en_q      <= 1'b0;
            vf_en_q      <= 1'b0;
            mem_w_en_q   <= 1'b0;
            mem_w_addr_q <= '0;
            mem_w_data_q <= '0;
            mem_r_en_q   <= 1'b0;
            mem_r_addr_q <= '0;
            pc_data_q    <= '0;
            pc_en_q      <= 1'b0;
            sp_data_q    <= '0;
            sp_en_q      <= 1'b0;
            i_data_q     <= '0;
            i_en_q       <= 1'b0;
            lfsr_q       <= LFSR_SEED;
        end else begin
            vx_addr_q    <= vx_addr_d;
            vx_data_q    <= vx_data_d;
            vf_data_q    <= vf_data_d;
            vx_en_q      <= vx_en_d;
            vf_en_q      <= vf_en_d;
            mem_w_en_q   <= mem_w_en_d;
            mem_w_addr_q <= mem_w_addr_d;
            mem_w_data_q <= mem_w_data_d;
            mem_r_en_q   <= mem_r_en_d;
            mem_r_addr_q <= mem_r_addr_d;
            pc_data_q    <= pc_data_d;
            pc_en_q      <= pc_en_d;
            sp_data_q    <= sp_data_d;
            sp_en_q      <= sp_en_d;
            i_data_q     <= i_data_d;
            i_en_q       <= i_en_d;
            lfsr_q       <= lfsr_d;
        end
    end

    assign o_vx_addr    = vx_addr_q;
    assign o_vx_data    = vx_data_q;
    assign o_vf_data    = vf_data_q;
    assign o_vx_en      = vx_en_q;
    assign o_vf_en      = vf_en_q;
    assign o_mem_w_en   = mem_w_en_q;
    assign o_mem_w_addr = mem_w_addr_q;
    assign o_mem_w_data = mem_w_data_q;
    assign o_mem_r_en   = mem_r_en_q;
    assign o_mem_r_addr = mem_r_addr_q;
    assign o_mem_r_data = '0;
    assign o_pc_data    = pc_data_q;
    assign o_pc_en      = pc_en_q;
    assign o_sp_data    = sp_data_q;
    assign o_sp_en      = sp_en_q;
    assign o_i_data     = i_data_q;
    assign o_i_en       = i_en_q;

endmodule

// File: tb/tb_execute.sv
// Randomized bench for the CHIP-8 execute stage against an arithmetic
// reference model of the instruction semantics, plus directed corner cases.
module tb_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  i_decode;
    logic [7:0]  i_byte_kk, i_vx_data, i_vy_data, i_sp_data;
    logic [3:0]  i_vx_addr;
    logic [11:0] i_mem_addr;
    logic [15:0] i_pc_data, i_i_data;
    logic [3:0]  o_vx_addr;
    logic [7:0]  o_vx_data, o_vf_data, o_sp_data;
    logic        o_vf_en, o_vx_en, o_mem_w_en, o_mem_r_en, o_pc_en, o_sp_en, o_i_en;
    logic [15:0] o_mem_w_addr, o_mem_w_data, o_mem_r_addr, o_mem_r_data;
    logic [15:0] o_pc_data, o_i_data;

    int n_vec = 0;
    int n_bad = 0;

    int e_vx_addr, e_vx_data, e_vf_data, e_vx_en, e_vf_en;
    int e_w_en, e_w_addr, e_w_data, e_r_en, e_r_addr;
    int e_pc, e_pc_en, e_sp, e_sp_en, e_i, e_i_en, e_lfsr;

    execute #(.STACK_BASE(16'h0EA0)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_decode     (i_decode),
        .i_byte_kk    (i_byte_kk),
        .i_vx_data    (i_vx_data),
        .i_vy_data    (i_vy_data),
        .i_vx_addr    (i_vx_addr),
        .o_vx_addr    (o_vx_addr),
        .o_vx_data    (o_vx_data),
        .o_vf_data    (o_vf_data),
        .o_vf_en      (o_vf_en),
        .o_vx_en      (o_vx_en),
        .i_mem_addr   (i_mem_addr),
        .i_pc_data    (i_pc_data),
        .i_sp_data    (i_sp_data),
        .i_i_data     (i_i_data),
        .o_mem_w_en   (o_mem_w_en),
        .o_mem_w_addr (o_mem_w_addr),
        .o_mem_w_data (o_mem_w_data),
        .o_mem_r_en   (o_mem_r_en),
        .o_mem_r_addr (o_mem_r_addr),
        .o_mem_r_data (o_mem_r_data),
        .o_pc_data    (o_pc_data),
        .o_pc_en      (o_pc_en),
        .o_sp_data    (o_sp_data),
        .o_sp_en      (o_sp_en),
        .o_i_data     (o_i_data),
        .o_i_en       (o_i_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("vx_addr",  int'(o_vx_addr),    e_vx_addr);
        check("vx_data",  int'(o_vx_data),    e_vx_data);
        check("vf_data",  int'(o_vf_data),    e_vf_data);
        check("vx_en",    int'(o_vx_en),      e_vx_en);
        check("vf_en",    int'(o_vf_en),      e_vf_en);
        check("mem_w_en", int'(o_mem_w_en),   e_w_en);
        check("mem_w_a",  int'(o_mem_w_addr), e_w_addr);
        check("mem_w_d",  int'(o_mem_w_data), e_w_data);
        check("mem_r_en", int'(o_mem_r_en),   e_r_en);
        check("mem_r_a",  int'(o_mem_r_addr), e_r_addr);
        check("mem_r_d",  int'(o_mem_r_data), 0);
        check("pc_data",  int'(o_pc_data),    e_pc);
        check("pc_en",    int'(o_pc_en),      e_pc_en);
        check("sp_data",  int'(o_sp_data),    e_sp);
        check("sp_en",    int'(o_sp_en),      e_sp_en);
        check("i_data",   int'(o_i_data),     e_i);
        check("i_en",     int'(o_i_en),       e_i_en);
        check("rw_excl",  int'(o_mem_w_en & o_mem_r_en), 0);
    endtask

    task automatic model_reset();
        e_vx_addr = 0; e_vx_data = 0; e_vf_data = 0; e_vx_en = 0; e_vf_en = 0;
        e_w_en = 0; e_w_addr = 0; e_w_data = 0; e_r_en = 0; e_r_addr = 0;
        e_pc = 0; e_pc_en = 0; e_sp = 0; e_sp_en = 0; e_i = 0; e_i_en = 0;
        e_lfsr = 'hA5;
    endtask

    // Instruction semantics with plain integer arithmetic
    task automatic model_step(input int op, input int kk, input int vx, input int vy,
                              input int x, input int nnn, input int pc, input int sp,
                              input int iv);
        bit cond;
        e_vx_en = 0; e_vf_en = 0; e_w_en = 0; e_r_en = 0;
        e_pc_en = 0; e_sp_en = 0; e_i_en = 0;
        e_vx_addr = x;
        case (op)
            1: begin e_pc = nnn; e_pc_en = 1; end
            2: begin
                e_w_addr = 'hEA0 + 2 * sp; e_w_data = pc; e_w_en = 1;
                e_sp = (sp + 1) % 256; e_sp_en = 1;
                e_pc = nnn; e_pc_en = 1;
            end
            3: begin
                e_r_addr = 'hEA0 + 2 * ((sp + 255) % 256); e_r_en = 1;
                e_sp = (sp + 255) % 256; e_sp_en = 1;
            end
            4, 5, 6, 7: begin
                cond = (op == 4) ? (vx == kk) : (op == 5) ? (vx != kk) :
                       (op == 6) ? (vx == vy) : (vx != vy);
                if (cond) begin e_pc = (pc + 2) % 65536; e_pc_en = 1; end
            end
            8:  begin e_vx_data = kk;              e_vx_en = 1; end
            9:  begin e_vx_data = (vx + kk) % 256; e_vx_en = 1; end
            10: begin e_vx_data = vy;              e_vx_en = 1; end
            11: begin e_vx_data = vx | vy;         e_vx_en = 1; end
            12: begin e_vx_data = vx & vy;         e_vx_en = 1; end
            13: begin e_vx_data = vx ^ vy;         e_vx_en = 1; end
            14: begin e_vx_data = (vx + vy) % 256;       e_vf_data = (vx + vy > 255) ? 1 : 0; end
            15: begin e_vx_data = (vx - vy + 256) % 256; e_vf_data = (vx >= vy) ? 1 : 0; end
            16: begin e_vx_data = vx / 2;                e_vf_data = vx % 2; end
            17: begin e_vx_data = (vy - vx + 256) % 256; e_vf_data = (vy >= vx) ? 1 : 0; end
            18: begin e_vx_data = (vx * 2) % 256;        e_vf_data = (vx >= 128) ? 1 : 0; end
            19: begin e_i = nnn; e_i_en = 1; end
            20: begin e_pc = nnn + vx; e_pc_en = 1; end
            21: begin e_vx_data = e_lfsr & kk; e_vx_en = 1; end
            22: begin e_i = (iv + vx) % 65536; e_i_en = 1; end
            default: ;
        endcase
        if (op >= 14 && op <= 18) begin e_vx_en = 1; e_vf_en = 1; end
        // LFSR advance: divide by x, reduce by x^8+x^6+x^5+x^4+1 when bit 0 falls out
        e_lfsr = (e_lfsr % 2 == 1) ? ((e_lfsr / 2) ^ 'hB8) : (e_lfsr / 2);
    endtask

    task automatic apply(input int op, input int kk, input int vx, input int vy,
                         input int x, input int nnn, input int pc, input int sp,
                         input int iv);
        i_decode   = 7'(op);
        i_byte_kk  = 8'(kk);
        i_vx_data  = 8'(vx);
        i_vy_data  = 8'(vy);
        i_vx_addr  = 4'(x);
        i_mem_addr = 12'(nnn);
        i_pc_data  = 16'(pc);
        i_sp_data  = 8'(sp);
        i_i_data   = 16'(iv);
        @(posedge clk);
        #1;
        model_step(op, kk, vx, vy, x, nnn, pc, sp, iv);
        compare_all();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        int op, sp, iv;
        rst = 1'b1;
        i_decode = '0; i_byte_kk = '0; i_vx_data = '0; i_vy_data = '0; i_vx_addr = '0;
        i_mem_addr = '0; i_pc_data = '0; i_sp_data = '0; i_i_data = '0;

        do_reset(2);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);

        apply(14, 0, 'hF0, 'h20, 3, 0, 0, 0, 0);
        check("add_addr", int'(o_vx_addr), 3);
        check("add_data", int'(o_vx_data), 'h10);
        check("add_vf",   int'(o_vf_data), 1);
        check("add_ens",  int'({o_vx_en, o_vf_en}), 3);
        apply(0, 0, 0, 0, 3, 0, 0, 0, 0);
        check("nop_ens",  int'({o_vx_en, o_vf_en, o_pc_en, o_sp_en, o_i_en, o_mem_w_en, o_mem_r_en}), 0);

        apply(15, 0, 'h05, 'h07, 1, 0, 0, 0, 0);
        check("sub_data", int'(o_vx_data), 'hFE);
        check("sub_vf",   int'(o_vf_data), 0);
        apply(18, 0, 'h81, 0, 2, 0, 0, 0, 0);
        check("shl_data", int'(o_vx_data), 'h02);
        check("shl_vf",   int'(o_vf_data), 1);

        apply(4, 'h42, 'h42, 0, 0, 0, 'h0202, 0, 0);
        check("se_pc",    int'(o_pc_data), 'h0204);
        check("se_en",    int'(o_pc_en), 1);
        apply(4, 'h41, 'h42, 0, 0, 0, 'h0202, 0, 0);
        check("se_no_en", int'(o_pc_en), 0);

        apply(2, 0, 0, 0, 0, 'h300, 'h0202, 1, 0);
        check("call_wa",  int'(o_mem_w_addr), 'h0EA2);
        check("call_wd",  int'(o_mem_w_data), 'h0202);
        check("call_sp",  int'(o_sp_data), 2);
        check("call_pc",  int'(o_pc_data), 'h0300);
        check("call_ens", int'({o_mem_w_en, o_sp_en, o_pc_en}), 7);
        apply(3, 0, 0, 0, 0, 0, 0, 2, 0);
        check("ret_ra",   int'(o_mem_r_addr), 'h0EA2);
        check("ret_sp",   int'(o_sp_data), 1);
        check("ret_pc_en", int'(o_pc_en), 0);
        apply(3, 0, 0, 0, 0, 0, 0, 0, 0);
        check("ret_wrap", int'(o_sp_data), 'hFF);

        apply(19, 0, 0, 0, 0, 'hABC, 0, 0, 0);
        check("ldi",      int'(o_i_data), 'h0ABC);
        apply(22, 0, 'h02, 0, 15, 0, 0, 0, 'hFFFF);
        check("addi",     int'(o_i_data), 'h0001);
        check("addi_vf",  int'(o_vf_en), 0);

        apply(21, 'hFF, 0, 0, 15, 0, 0, 0, 0);
        apply(16, 0, 'h03, 0, 15, 0, 0, 0, 0);
        check("xf_ens",   int'({o_vx_en, o_vf_en}), 3);

        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset(1);
            op = $urandom_range(0, 27);
            sp = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 255 : 0)
                                             : $urandom_range(0, 255);
            iv = ($urandom_range(0, 7) == 0) ? 'hFFFF : $urandom_range(0, 65535);
            apply(op, $urandom_range(0, 255), $urandom_range(0, 255),
                  ($urandom_range(0, 3) == 0) ? 'h42 : $urandom_range(0, 255),
                  $urandom_range(0, 15), $urandom_range(0, 4095),
                  ($urandom_range(0, 7) == 0) ? 'hFFFE : $urandom_range(0, 65535),
                  sp, iv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
